// File: rtl/keystream_xor.sv
// -----------------------------------------------------------------------------
// keystream_xor
//
// Packs a serial keystream (one bit per cycle, e.g. A5/1 out_key) into bytes
// and XORs each completed keystream byte with one data byte. There is a
// one-byte hold register between the bit gatherer and the XOR stage. The next
// byte can therefore be gathered while the previous one waits for data, and a
// full run streams at one byte every 8 cycles.
//
// Parameters
//   NBYTES     bytes emitted per run before the block parks in DONE
//   LSB_FIRST  1: first keystream bit of a byte lands in bit 0; 0: in bit 7
//
// Ports
//   clk         clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a run from IDLE or DONE
//   ks_bit      serial keystream bit
//   ks_valid    ks_bit is valid
//   ks_ready    block accepts ks_bit this cycle
//   din         input data byte
//   din_valid   din is valid
//   din_ready   din accepted this cycle when din_valid is also high
//   dout        din XOR keystream byte
//   dout_valid  dout holds a result
//   dout_ready  downstream consumes dout this cycle
//   byte_cnt    bytes emitted in the current run (saturates at NBYTES)
//   done        high while in DONE
// -----------------------------------------------------------------------------
module keystream_xor #(
    parameter int NBYTES    = 65536,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(NBYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ks_bit,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT_M1 = CNT_W'(NBYTES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_gather;
    logic [7:0]       r_kb;
    logic             r_kb_valid;
    logic [7:0]       r_dout;
    logic             r_dout_valid;
    logic [CNT_W-1:0] r_byte_cnt;

    logic             w_run;
    logic             w_start_ok;
    logic             w_ks_xfer;
    logic             w_din_xfer;
    logic             w_dout_xfer;
    logic             w_last_bit;
    logic             w_last_byte;
    logic [2:0]       w_bit_pos;
    logic [7:0]       w_gather_next;

    assign w_run      = (r_state == S_RUN);
    assign w_start_ok = start & (r_state != S_RUN);

    // A din transfer consumes the hold register. This is the kb_consume term.
    assign din_ready  = w_run & r_kb_valid & (~r_dout_valid | dout_ready);
    assign w_din_xfer = din_valid & din_ready;

    // The 8th bit may be gathered while the full hold register is being
    // consumed in the same cycle. The new byte replaces the old one, and no
    // bubble is inserted.
    assign ks_ready   = w_run & ((r_bit_cnt != 3'd7) | ~r_kb_valid | w_din_xfer);
    assign w_ks_xfer  = ks_valid & ks_ready;
    assign w_last_bit = w_ks_xfer & (r_bit_cnt == 3'd7);

    assign w_dout_xfer = r_dout_valid & dout_ready;
    assign w_last_byte = w_dout_xfer & (r_byte_cnt == LAST_CNT_M1);

    assign w_bit_pos = LSB_FIRST ? r_bit_cnt : (3'd7 - r_bit_cnt);

    // Every bit position is overwritten once per byte. The gather register
    // therefore never needs clearing between bytes.
    always_comb begin
        // NOTE: default first so that no path leaves the signal unassigned (no latch).
        w_gather_next            = r_gather;
        w_gather_next[w_bit_pos] = ks_bit;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all clocked state, so every
            // flop samples values from before the edge.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_state_next = S_RUN;
            S_RUN:   if (w_last_byte) w_state_next = S_DONE;
            S_DONE:  if (start)       w_state_next = S_RUN;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: gather, hold register, output register, byte counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 3'd0;
            r_gather     <= 8'h00;
            r_kb         <= 8'h00;
            r_kb_valid   <= 1'b0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_byte_cnt   <= '0;
        end else if (w_start_ok) begin
            // A new run discards whatever the previous run left behind.
            r_bit_cnt    <= 3'd0;
            r_gather     <= 8'h00;
            r_kb         <= 8'h00;
            r_kb_valid   <= 1'b0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_byte_cnt   <= '0;
        end else begin
            if (w_ks_xfer) begin
                r_gather  <= w_gather_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;   // wraps 7 -> 0
            end

            // The completed byte, including the bit arriving on this edge,
            // goes straight to the hold register.
            if (w_last_bit) begin
                r_kb       <= w_gather_next;
                r_kb_valid <= 1'b1;
            end else if (w_din_xfer) begin
                r_kb_valid <= 1'b0;
            end

            if (w_din_xfer) begin
                r_dout       <= din ^ r_kb;
                r_dout_valid <= 1'b1;
            end else if (w_dout_xfer) begin
                r_dout_valid <= 1'b0;
            end

            if (w_dout_xfer && (r_byte_cnt != LAST_CNT)) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign byte_cnt   = r_byte_cnt;
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_keystream_xor.sv
// -----------------------------------------------------------------------------
// tb_keystream_xor
//
// Testbench for keystream_xor. Two instances share all inputs:
//   dut_a  LSB_FIRST = 1
//   dut_b  LSB_FIRST = 0
// Both use NBYTES = 4. Keystream bytes in the tables are written in
// arrival-order form: bit k is the k-th keystream bit presented.
// -----------------------------------------------------------------------------
module tb_keystream_xor;

    localparam int NB = 4;
    localparam int CW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ks_bit = 1'b0;
    logic          ks_valid = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          din_valid = 1'b0;
    logic          dout_ready = 1'b0;

    logic          ks_ready_a, din_ready_a, dout_valid_a, done_a;
    logic [7:0]    dout_a;
    logic [CW-1:0] byte_cnt_a;
    logic          ks_ready_b, din_ready_b, dout_valid_b, done_b;
    logic [7:0]    dout_b;
    logic [CW-1:0] byte_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keystream_xor #(.NBYTES(NB), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready_a),
        .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
        .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
        .byte_cnt(byte_cnt_a), .done(done_a)
    );

    keystream_xor #(.NBYTES(NB), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready_b),
        .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
        .byte_cnt(byte_cnt_b), .done(done_b)
    );

    typedef struct {
        logic [7:0] ks;        // arrival order, bit k = k-th bit
        logic [7:0] din;
        logic [7:0] exp_lsb;   // expected dout, LSB_FIRST = 1
        logic [7:0] exp_msb;   // expected dout, LSB_FIRST = 0
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] s_ks[4];
    logic [7:0] s_din[4];
    logic [7:0] s_exp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        ks_valid   = 1'b0;
        ks_bit     = 1'b0;
        din_valid  = 1'b0;
        din        = 8'h00;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            ks_valid = 1'b1;
            ks_bit   = b[3'(k)];
            @(negedge clk);
        end
        ks_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},       32'(dout_a),       32'h00);
        check({tag, "_dout_valid"}, 32'(dout_valid_a), 32'd0);
        check({tag, "_ks_ready"},   32'(ks_ready_a),   32'd0);
        check({tag, "_din_ready"},  32'(din_ready_a),  32'd0);
        check({tag, "_done"},       32'(done_a),       32'd0);
        check({tag, "_byte_cnt"},   32'(byte_cnt_a),   32'd0);
    endtask

    // Streams nb bytes through dut_a with every valid held high, unless toggle
    // is set. dout_ready stays low for the first `stall` cycles. Each emitted
    // byte is compared against s_exp[]. When gap > 0, consecutive outputs
    // must be exactly gap cycles apart.
    task automatic run_stream(input string tag, input int nb, input int stall,
                              input bit toggle, input int gap);
        int         kidx = 0;
        int         didx = 0;
        int         oidx = 0;
        int         cyc  = 0;
        int         t_prev = 0;
        int         gap_bad = 0;
        int         stall_bad = 0;
        logic [7:0] cur;
        while (oidx < nb && cyc < 600) begin
            if (kidx < nb * 8) begin
                cur      = s_ks[2'(kidx / 8)];
                ks_bit   = cur[3'(kidx % 8)];
                ks_valid = !toggle || ((cyc % 2) == 0);
            end else begin
                ks_bit   = 1'b0;
                ks_valid = 1'b0;
            end
            din_valid  = (didx < nb);
            din        = (didx < nb) ? s_din[2'(didx)] : 8'h00;
            dout_ready = (cyc >= stall);
            #1;
            if (cyc >= 10 && cyc < stall) begin
                if (dout_valid_a !== 1'b1 || dout_a !== s_exp[0]) stall_bad++;
            end
            if (stall > 0 && cyc == stall - 1) begin
                check({tag, "_ks_ready_full"},  32'(ks_ready_a),  32'd0);
                check({tag, "_din_ready_full"}, 32'(din_ready_a), 32'd0);
            end
            if (dout_valid_a && dout_ready) begin
                check($sformatf("%s_dout%0d", tag, oidx), 32'(dout_a), 32'(s_exp[2'(oidx)]));
                if (oidx > 0 && gap > 0 && (cyc - t_prev) != gap) gap_bad++;
                t_prev = cyc;
                oidx++;
            end
            if (ks_valid && ks_ready_a) kidx++;
            if (din_valid && din_ready_a) didx++;
            @(negedge clk);
            cyc++;
        end
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        check({tag, "_bytes_out"}, 32'(oidx), 32'(nb));
        if (stall > 0) check({tag, "_stall_stable_errs"}, 32'(stall_bad), 32'd0);
        if (gap > 0)   check({tag, "_gap_errs"},          32'(gap_bad),   32'd0);
    endtask

    initial begin
        vecs[0] = '{ks: 8'h8D, din: 8'h00, exp_lsb: 8'h8D, exp_msb: 8'hB1};
        vecs[1] = '{ks: 8'h8D, din: 8'hFF, exp_lsb: 8'h72, exp_msb: 8'h4E};
        vecs[2] = '{ks: 8'h01, din: 8'h00, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[3] = '{ks: 8'hF0, din: 8'h3C, exp_lsb: 8'hCC, exp_msb: 8'h33};

        // ---------------- reset state ----------------
        do_reset();
        ks_valid = 1'b1;
        #1;
        check_reset_outputs("por");
        ks_valid = 1'b0;
        check("por_done_b", 32'(done_b), 32'd0);

        // ---------------- table: one run of NB single bytes ----------------
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            feed_byte(vecs[i].ks, 8);
            din        = vecs[i].din;
            din_valid  = 1'b1;
            dout_ready = 1'b0;
            #1;
            check($sformatf("vec%0d_din_ready", i), 32'(din_ready_a), 32'd1);
            @(negedge clk);
            din_valid = 1'b0;
            check($sformatf("vec%0d_dout_valid", i), 32'(dout_valid_a), 32'd1);
            check($sformatf("vec%0d_dout_lsb", i), 32'(dout_a), 32'(vecs[i].exp_lsb));
            check($sformatf("vec%0d_dout_msb", i), 32'(dout_b), 32'(vecs[i].exp_msb));
            dout_ready = 1'b1;
            @(negedge clk);
            dout_ready = 1'b0;
            check($sformatf("vec%0d_byte_cnt", i), 32'(byte_cnt_a), 32'(i + 1));
            if (i == 0) begin
                pulse_start();   // ignored while running
                check("start_in_run_cnt",  32'(byte_cnt_a), 32'd1);
                check("start_in_run_done", 32'(done_a),     32'd0);
            end
        end
        ks_valid  = 1'b1;
        din_valid = 1'b1;
        #1;
        check("tbl_done",      32'(done_a),      32'd1);
        check("tbl_ks_ready",  32'(ks_ready_a),  32'd0);
        check("tbl_din_ready", 32'(din_ready_a), 32'd0);
        ks_valid  = 1'b0;
        din_valid = 1'b0;
        pulse_start();
        ks_valid = 1'b1;
        #1;
        check("restart_done",     32'(done_a),     32'd0);
        check("restart_byte_cnt", 32'(byte_cnt_a), 32'd0);
        check("restart_ks_ready", 32'(ks_ready_a), 32'd1);
        ks_valid = 1'b0;

        // ---------------- output back-pressure for 20 cycles ----------------
        do_reset();
        pulse_start();
        s_ks  = '{8'h12, 8'hC7, 8'h5A, 8'h00};
        s_din = '{8'h00, 8'hFF, 8'h0F, 8'h00};
        s_exp = '{8'h12, 8'h38, 8'h55, 8'h00};
        run_stream("stall", 3, 30, 1'b0, 0);
        check("stall_byte_cnt", 32'(byte_cnt_a), 32'd3);

        // ---------------- continuous full run: 1 byte / 8 cycles ----------------
        do_reset();
        pulse_start();
        s_ks  = '{8'hE1, 8'h0F, 8'h80, 8'h3B};
        s_din = '{8'h00, 8'h00, 8'hFF, 8'hA5};
        s_exp = '{8'hE1, 8'h0F, 8'h7F, 8'h9E};
        run_stream("cont", 4, 0, 1'b0, 8);
        ks_valid   = 1'b1;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        #1;
        check("cont_done",      32'(done_a),      32'd1);
        check("cont_byte_cnt",  32'(byte_cnt_a),  32'd4);
        check("cont_ks_ready",  32'(ks_ready_a),  32'd0);
        check("cont_din_ready", 32'(din_ready_a), 32'd0);
        @(negedge clk);
        check("cont_byte_cnt_sat", 32'(byte_cnt_a), 32'd4);
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // ---------------- ks_valid toggling: same bytes, half rate ----------------
        do_reset();
        pulse_start();
        run_stream("toggle", 4, 0, 1'b1, 16);
        #1;
        check("toggle_done", 32'(done_a), 32'd1);

        // ---------------- reset mid-byte with pending output ----------------
        do_reset();
        pulse_start();
        feed_byte(8'h5A, 8);
        din       = 8'h00;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        feed_byte(8'hFF, 5);
        check("midrst_pending", 32'(dout_valid_a), 32'd1);
        ks_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int idle_bad = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (ks_ready_a !== 1'b0 || dout_valid_a !== 1'b0) idle_bad++;
            end
            check("midrst_idle_errs", 32'(idle_bad), 32'd0);
        end
        ks_valid = 1'b0;
        pulse_start();
        feed_byte(8'h96, 8);
        din       = 8'h00;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("midrst_fresh_lsb", 32'(dout_a), 32'h96);
        check("midrst_fresh_msb", 32'(dout_b), 32'h69);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keystream_xor.md
KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 Parameter: NBYTES, 65536, number of bytes processed per run before DONE.
REQ-002 Parameter: LSB_FIRST, 1, 1 = first keystream bit lands in byte bit 0; 0 = first bit lands in bit 7.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 ks_bit  input  1  serial keystream bit from the A5/1 cipher (out_key).
REQ-007 ks_valid  input  1  keystream bit valid (driven from ~init_flag).
REQ-008 ks_ready  output  1  block accepts ks_bit this cycle.
REQ-009 din  input  8  plaintext/ciphertext byte.
REQ-010 din_valid  input  1  din valid.
REQ-011 din_ready  output  1  din accepted this cycle when din_valid is also high.
REQ-012 dout  output  8  din XOR assembled keystream byte.
REQ-013 dout_valid  output  1  dout holds a result.
REQ-014 dout_ready  input  1  downstream consumes dout.
REQ-015 byte_cnt  output  clog2(NBYTES+1)  bytes emitted in current run.
REQ-016 done  output  1  high in DONE state.

Function
REQ-017 States: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE when the NBYTES-th output byte is consumed (dout_valid & dout_ready); DONE->RUN on start.
REQ-018 start in RUN is ignored. Start in IDLE or DONE clears byte_cnt, gather register, bit counter, hold register and output register in the same edge.
REQ-019 Gather: a bit transfers on ks_valid & ks_ready; a 3-bit counter wraps 7->0. With LSB_FIRST=1, bit k of the run goes to byte position k mod 8. With LSB_FIRST=0, it goes to position 7-(k mod 8).
REQ-020 Hold register (kb, kb_valid): on the 8th gathered bit, the completed byte moves into kb in that same edge, together with the 8th bit, and kb_valid is set.
REQ-021 ks_ready = RUN & ((bit_cnt != 7) | ~kb_valid | kb_consume).
REQ-021a The gather of the 8th bit and consumption of the old kb in the same cycle SHALL both succeed, so there are no bubbles.
REQ-022 din_ready = RUN & kb_valid & (~dout_valid | dout_ready).
REQ-022a A din transfer sets kb_consume for that cycle, which clears kb_valid unless a new byte is loaded in the same edge.
REQ-023 Latency: dout = din ^ kb and dout_valid = 1 one cycle after the din transfer.
REQ-023a dout_valid stays high and dout stays stable until dout_ready.
REQ-024 Throughput: one byte every 8 cycles when ks_valid, din_valid and dout_ready are held high.
REQ-025 byte_cnt increments on each dout transfer and saturates at NBYTES. On reaching NBYTES, ks_ready and din_ready are low from the next cycle.
REQ-026 ks_valid low mid-byte: the bit counter and partial byte are held, with no loss or duplication.
REQ-027 Keystream bits arriving outside RUN are not accepted (ks_ready = 0).

Reset
REQ-028 rst_n low, asynchronously: state=IDLE; dout=8'h00; dout_valid=0; ks_ready=0; din_ready=0; done=0; byte_cnt=0; bit counter, gather register and kb_valid all cleared.
REQ-029 Reset asserted mid-run discards any partial byte and pending output; after release, nothing happens until start.

Verification
REQ-030 LSB_FIRST=1, start, ks bits 1,0,1,1,0,0,0,1 then din=8'h00 -> dout=8'h8D, dout_valid one cycle after the din transfer.
REQ-031 Same bits, din=8'hFF -> dout=8'h72. Same bits with LSB_FIRST=0, din=8'h00 -> dout=8'hB1.
REQ-032 dout_ready held low 20 cycles with continuous ks_valid/din_valid -> dout stable; exactly one kb byte buffered; ks_ready low once gather is full; no byte lost after release.
REQ-033 NBYTES=4, all handshakes high -> exactly 4 dout transfers, byte_cnt=4, done=1, ks_ready=din_ready=0; a start pulse returns to RUN with byte_cnt=0.
REQ-034 rst_n pulsed low after 5 of 8 bits -> all outputs at reset values immediately; after start, the next 8 bits form a fresh byte.
REQ-035 ks_valid toggled 1/0 every cycle -> bytes identical to the continuous-stream case, at half the rate.
